// File: rtl/clock_switch_ctrl_pkg.sv
// Shared encodings for the core/io clock-switch sequencer.
package clock_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SWAP   = 2'd2,
    ST_UNGATE = 2'd3
  } state_t;

  localparam logic SEL_CORE = 1'b0;
  localparam logic SEL_IO   = 1'b1;

endpackage

// File: rtl/clock_switch_ctrl_presence_det.sv
// io_clock presence detector: synchronises io_clock_raw, counts its rising edges per
// fixed core_clock window and reports whether enough edges were seen in the last window.
module clk_presence_det #(
  parameter int DET_WINDOW = 64,
  parameter int MIN_EDGES  = 4
) (
  input  logic core_clock,
  input  logic core_reset,
  input  logic io_clock_raw,
  output logic io_clk_ok
);

  localparam int WIN_W  = (DET_WINDOW > 1) ? $clog2(DET_WINDOW) : 1;
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(DET_WINDOW - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(MIN_EDGES);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_edge_q;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic              r_ok;
  logic              w_rise;
  logic              w_wrap;

  assign w_rise    = r_sync2 & ~r_edge_q;
  assign w_wrap    = (r_win_cnt == WIN_LAST);
  assign io_clk_ok = r_ok;

  always_ff @(posedge core_clock) begin
    if (core_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge_q <= 1'b0;
    end else begin
      r_sync1  <= io_clock_raw;
      r_sync2  <= r_sync1;
      r_edge_q <= r_sync2;
    end
  end

  // An edge landing on the wrap cycle is credited to the window that starts there.
  always_ff @(posedge core_clock) begin
    if (core_reset) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_ok       <= 1'b0;
    end else if (w_wrap) begin
      r_win_cnt  <= '0;
      r_ok       <= (r_edge_cnt >= EDGE_MAX);
      r_edge_cnt <= w_rise ? EDGE_W'(1) : '0;
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
      if (w_rise && (r_edge_cnt < EDGE_MAX)) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_switch_ctrl.sv
// Glitch-free core/io clock mux sequencer: gate, settle, flip select, settle, ungate.
// Refuses switches to a dead io_clock and falls back to core_clock when io_clock stops.
module clock_switch_ctrl
  import clock_switch_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DET_WINDOW    = 64,
  parameter int MIN_EDGES     = 4
) (
  input  logic core_clock,
  input  logic core_reset,
  input  logic sel_req,
  input  logic io_clock_raw,
  input  logic err_clr,
  output logic sel_out,
  output logic clk_en,
  output logic busy,
  output logic io_clk_ok,
  output logic switch_err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sel_req_q;
  logic             r_target;
  logic             w_target_nxt;
  logic             r_sel_out;
  logic             w_sel_nxt;
  logic             r_clk_en;
  logic             w_clk_en_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_switch_err;
  logic             w_err_set;
  logic             w_err_nxt;
  logic             w_io_ok;

  clk_presence_det #(
    .DET_WINDOW (DET_WINDOW),
    .MIN_EDGES  (MIN_EDGES)
  ) u_presence (
    .core_clock   (core_clock),
    .core_reset   (core_reset),
    .io_clock_raw (io_clock_raw),
    .io_clk_ok    (w_io_ok)
  );

  assign sel_out    = r_sel_out;
  assign clk_en     = r_clk_en;
  assign busy       = r_busy;
  assign io_clk_ok  = w_io_ok;
  assign switch_err = r_switch_err;

  always_ff @(posedge core_clock) begin
    if (core_reset) begin
      r_sel_req_q  <= SEL_CORE;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_target     <= SEL_CORE;
      r_sel_out    <= SEL_CORE;
      r_clk_en     <= 1'b1;
      r_busy       <= 1'b0;
      r_switch_err <= 1'b0;
    end else begin
      r_sel_req_q  <= sel_req;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_sel_out    <= w_sel_nxt;
      r_clk_en     <= w_clk_en_nxt;
      r_busy       <= w_busy_nxt;
      r_switch_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_sel_nxt    = r_sel_out;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sel_req_q != r_sel_out) begin
          if ((r_sel_req_q == SEL_IO) && !w_io_ok) begin
            w_err_set = 1'b1;
          end else begin
            w_state_nxt  = ST_GATE;
            w_target_nxt = r_sel_req_q;
            w_cnt_nxt    = SETTLE_LAST;
          end
        end else if ((r_sel_out == SEL_IO) && !w_io_ok) begin
          w_state_nxt  = ST_GATE;
          w_target_nxt = SEL_CORE;
          w_cnt_nxt    = SETTLE_LAST;
          w_err_set    = 1'b1;
        end
      end
      ST_GATE: begin
        // Losing io_clock while still gated redirects the switch back to core.
        if ((r_target == SEL_IO) && !w_io_ok) begin
          w_target_nxt = SEL_CORE;
        end
        if (r_cnt == '0) begin
          w_state_nxt = ST_SWAP;
          w_sel_nxt   = w_target_nxt;
          w_cnt_nxt   = SETTLE_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_SWAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_UNGATE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_UNGATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clk_en_nxt = !((w_state_nxt == ST_GATE) || (w_state_nxt == ST_SWAP));
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_err_nxt    = w_err_set | (r_switch_err & ~err_clr);
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl: vector table for the switch sequences plus
// hand-written fallback, refusal, error-clear and mid-switch reset scenarios.
module tb_clock_switch_ctrl;

  logic core_clock;
  logic core_reset;
  logic sel_req;
  logic io_clock_raw;
  logic err_clr;
  logic sel_out;
  logic clk_en;
  logic busy;
  logic io_clk_ok;
  logic switch_err;
  logic io_en;

  int totalChecks;
  int passedChecks;

  typedef struct packed {
    logic selReq;
    logic expSel;
    logic expClkEn;
    logic expBusy;
  } vec_t;

  vec_t vecs [33];

  clock_switch_ctrl dut (
    .core_clock   (core_clock),
    .core_reset   (core_reset),
    .sel_req      (sel_req),
    .io_clock_raw (io_clock_raw),
    .err_clr      (err_clr),
    .sel_out      (sel_out),
    .clk_en       (clk_en),
    .busy         (busy),
    .io_clk_ok    (io_clk_ok),
    .switch_err   (switch_err)
  );

  initial begin
    core_clock = 1'b0;
    forever #5 core_clock = ~core_clock;
  end

  // io_clock at core/8 while enabled, parked low otherwise
  initial begin
    io_clock_raw = 1'b0;
    forever begin
      #40;
      if (io_en) io_clock_raw = ~io_clock_raw;
      else io_clock_raw = 1'b0;
    end
  end

  task automatic tick();
    @(negedge core_clock);
  endtask

  task automatic applyStimulus(input logic s, input logic e);
    sel_req = s;
    err_clr = e;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic checkAll(input string name, input logic s, input logic e, input logic b,
                          input logic ok, input logic er);
    checkOutput({name, ".sel_out"}, sel_out, s);
    checkOutput({name, ".clk_en"}, clk_en, e);
    checkOutput({name, ".busy"}, busy, b);
    checkOutput({name, ".io_clk_ok"}, io_clk_ok, ok);
    checkOutput({name, ".switch_err"}, switch_err, er);
  endtask

  task automatic waitOk(input logic val, input int budget, input string name);
    for (int i = 0; i < budget && io_clk_ok !== val; i++) tick();
    checkOutput(name, io_clk_ok, val);
  endtask

  function automatic vec_t mk(input logic s, input logic sel, input logic en, input logic b);
    vec_t v;
    v.selReq = s; v.expSel = sel; v.expClkEn = en; v.expBusy = b;
    return v;
  endfunction

  initial begin
    totalChecks = 0;
    passedChecks = 0;
    io_en = 1'b0;
    sel_req = 1'b0;
    err_clr = 1'b0;
    core_reset = 1'b1;

    // switch to io (0..11), then 1->0->1 during GATE (12..32)
    vecs[0] = mk(1, 0, 1, 0);
    for (int i = 1; i <= 4; i++) vecs[i] = mk(1, 0, 0, 1);
    for (int i = 5; i <= 8; i++) vecs[i] = mk(1, 1, 0, 1);
    vecs[9]  = mk(1, 1, 1, 1);
    vecs[10] = mk(1, 1, 1, 0);
    vecs[11] = mk(1, 1, 1, 0);
    vecs[12] = mk(0, 1, 1, 0);
    vecs[13] = mk(0, 1, 0, 1);
    for (int i = 14; i <= 16; i++) vecs[i] = mk(1, 1, 0, 1);
    for (int i = 17; i <= 20; i++) vecs[i] = mk(1, 0, 0, 1);
    vecs[21] = mk(1, 0, 1, 1);
    vecs[22] = mk(1, 0, 1, 0);
    for (int i = 23; i <= 26; i++) vecs[i] = mk(1, 0, 0, 1);
    for (int i = 27; i <= 30; i++) vecs[i] = mk(1, 1, 0, 1);
    vecs[31] = mk(1, 1, 1, 1);
    vecs[32] = mk(1, 1, 1, 0);

    tick();
    tick();
    checkAll("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    core_reset = 1'b0;

    for (int i = 0; i < 128; i++) tick();
    checkAll("noIo", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    io_en = 1'b1;
    waitOk(1'b1, 200, "ioOkRise");

    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i].selReq, 1'b0);
      checkOutput($sformatf("vec%0d.sel_out", i), sel_out, vecs[i].expSel);
      checkOutput($sformatf("vec%0d.clk_en", i), clk_en, vecs[i].expClkEn);
      checkOutput($sformatf("vec%0d.busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d.io_clk_ok", i), io_clk_ok, 1'b1);
      checkOutput($sformatf("vec%0d.switch_err", i), switch_err, 1'b0);
    end

    // io_clock stops while selected: forced fallback through the full sequence
    io_en = 1'b0;
    waitOk(1'b0, 200, "ioOkFall");
    checkAll("fallWrap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("fallGate", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkAll("fallSwap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkAll("fallUngate", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkAll("fallIdle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // sel_req still 1 with io dead: refused, error re-asserts over err_clr
    for (int i = 0; i < 20; i++) tick();
    checkAll("refuse", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    err_clr = 1'b0;
    checkOutput("errSetWins", switch_err, 1'b1);
    applyStimulus(1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1);
    err_clr = 1'b0;
    checkAll("errCleared", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset in the middle of SWAP aborts immediately
    io_en = 1'b1;
    waitOk(1'b1, 200, "ioOkRise2");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkAll("inSwap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    core_reset = 1'b1;
    sel_req = 1'b0;
    tick();
    checkAll("swapReset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    core_reset = 1'b0;
    tick();
    tick();
    checkAll("postReset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
